pcie_dma_mwr_rx_ctrl: RTL



---
 rtl/pcie_dma_pkg.sv | 34 +++
 rtl/pcie_mwr_be_gen.sv | 32 +++
 rtl/pcie_dma_mwr_rx_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_dma_pkg.sv
// Shared definitions for the DMA TLP path: header field positions, MWr fmt/type codes,
// receive FSM encoding and the per-DW big-to-little endian byte swap.
package pcie_dma_pkg;

  localparam logic [7:0] MWR32 = 8'h40;
  localparam logic [7:0] MWR64 = 8'h60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } mwr_rx_state_e;

  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_LEN_MSB  = 9;
  localparam int HDR_TYPE_LSB = 24;
  localparam int HDR_FMT_MSB  = 31;
  localparam int HDR_FBE_LSB  = 32;
  localparam int HDR_LBE_LSB  = 36;
  localparam int HDR_TAG_LSB  = 40;
  localparam int HDR_RID_LSB  = 48;
  localparam int HDR_A3_LSB   = 66;   // addr[31:2] of a 3DW header
  localparam int HDR_A4_LSB   = 98;   // addr[31:2] of a 4DW header

  function automatic logic [127:0] endian_convert(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = d[8*((i & ~3) + 3 - (i & 3)) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_mwr_be_gen.sv
// Byte-enable generator for one 128-bit payload beat: first_be on the first DW, last_be on
// the last DW, zero past the end of the payload, all ones elsewhere.
module pcie_mwr_be_gen (
  input  logic [3:0]  first_be,
  input  logic [3:0]  last_be,
  input  logic [1:0]  len_lo,
  input  logic        first_beat,
  input  logic        last_beat,
  output logic [15:0] be
);

  logic [1:0] last_dw;
  logic       single_dw;

  // len[1:0]==0 means the final beat is full, so the last DW sits in lane 3
  assign last_dw   = len_lo - 2'd1;
  assign single_dw = first_beat && last_beat && (len_lo == 2'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dw
      localparam logic [1:0] DW_IDX = 2'(gi);
      logic [3:0] dw_be;
      assign dw_be = (last_beat && (DW_IDX > last_dw))                  ? 4'h0 :
                     (last_beat && (DW_IDX == last_dw) && !single_dw)   ? last_be :
                     (first_beat && (gi == 0))                          ? first_be :
                                                                          4'hf;
      assign be[4*gi +: 4] = dw_be;
    end
  endgenerate

endmodule

// File: rtl/pcie_dma_mwr_rx_ctrl.sv
// Receive side of the DMA MWr path: parses 3DW/4DW MWr headers and writes byte-swapped payload
// to the DMA RAM. Define PCIE_MWR_RX_STAT_EN for saturating good/drop counters with i_stat_clr.
module pcie_dma_mwr_rx_ctrl
  import pcie_dma_pkg::*;
#(
  parameter int RAM_AW  = 12,
  parameter int BAR_NUM = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_axis_master_tvld,
  output logic              o_axis_master_trdy,
  input  logic [127:0]      i_axis_master_tdata,
  input  logic              i_axis_master_tlast,
  input  logic [7:0]        i_axis_master_tuser,
  input  logic              i_ram_rdy,
  output logic              o_wr_en,
  output logic [RAM_AW-1:0] o_wr_addr,
  output logic [127:0]      o_wr_data,
  output logic [15:0]       o_wr_be,
  output logic              o_mwr_rx_busy,
  output logic              o_mwr_done,
  output logic              o_len_err,
  output logic              o_align_err,
  output logic [7:0]        o_rx_tag,
`ifdef PCIE_MWR_RX_STAT_EN
  input  logic              i_stat_clr,
  output logic [15:0]       o_rx_tlp_cnt,
  output logic [15:0]       o_rx_drop_cnt,
`endif
  output logic [15:0]       o_rx_req_id
);

  mwr_rx_state_e     state_reg, state_next;
  logic [RAM_AW-1:0] addr_reg, addr_next;
  logic [8:0]        beats_reg, beats_next;
  logic [3:0]        fbe_reg, fbe_next, lbe_reg, lbe_next;
  logic [1:0]        len_lo_reg, len_lo_next;
  logic              first_reg, first_next;

  logic              wr_en_reg, wr_en_next;
  logic [RAM_AW-1:0] wr_addr_reg, wr_addr_next;
  logic [127:0]      wr_data_reg, wr_data_next;
  logic [15:0]       wr_be_reg, wr_be_next;
  logic              done_reg, done_next;
  logic              len_err_reg, len_err_next;
  logic              align_err_reg, align_err_next;
  logic              drop_reg, drop_next;
  logic [7:0]        tag_reg, tag_next;
  logic [15:0]       rid_reg, rid_next;

  logic [7:0]        hdr_ft;
  logic [9:0]        hdr_len;
  logic [10:0]       hdr_len_ext, hdr_beats_sum;
  logic [8:0]        hdr_beats;
  logic [31:0]       hdr_addr;
  logic              hdr_is_mwr, hdr_is_4dw, bar_hit, last_beat, beat_acc;
  logic [15:0]       beat_be;

  assign hdr_ft        = i_axis_master_tdata[HDR_FMT_MSB:HDR_TYPE_LSB];
  assign hdr_len       = i_axis_master_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_is_mwr    = (hdr_ft & 8'h5f) == (MWR32 & 8'h5f);
  assign hdr_is_4dw    = (hdr_ft & MWR64) == MWR64;
  assign hdr_addr      = hdr_is_4dw ? {i_axis_master_tdata[HDR_A4_LSB +: 30], 2'b00}
                                    : {i_axis_master_tdata[HDR_A3_LSB +: 30], 2'b00};
  assign hdr_len_ext   = (hdr_len == 10'd0) ? 11'd1024 : {1'b0, hdr_len};
  assign hdr_beats_sum = hdr_len_ext + 11'd3;
  assign hdr_beats     = hdr_beats_sum[10:2];
  assign bar_hit       = i_axis_master_tuser[BAR_NUM+1];
  assign last_beat     = (beats_reg == 9'd1);

  logic unused_ok;
  assign unused_ok = ^{i_axis_master_tuser, hdr_addr, hdr_beats_sum[1:0]};

  pcie_mwr_be_gen u_be_gen (
    .first_be   (fbe_reg),
    .last_be    (lbe_reg),
    .len_lo     (len_lo_reg),
    .first_beat (first_reg),
    .last_beat  (last_beat),
    .be         (beat_be)
  );

  always_comb begin
    state_next         = state_reg;
    addr_next          = addr_reg;
    beats_next         = beats_reg;
    fbe_next           = fbe_reg;
    lbe_next           = lbe_reg;
    len_lo_next        = len_lo_reg;
    first_next         = first_reg;
    wr_en_next         = 1'b0;
    wr_addr_next       = wr_addr_reg;
    wr_data_next       = wr_data_reg;
    wr_be_next         = wr_be_reg;
    done_next          = 1'b0;
    len_err_next       = 1'b0;
    align_err_next     = 1'b0;
    drop_next          = 1'b0;
    tag_next           = tag_reg;
    rid_next           = rid_reg;
    o_axis_master_trdy = 1'b0;
    beat_acc           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        o_axis_master_trdy = 1'b1;
        if (i_axis_master_tvld) begin
          if (hdr_is_mwr && bar_hit) begin
            if (hdr_addr[3:2] != 2'b00) begin
              align_err_next = 1'b1;
              state_next     = i_axis_master_tlast ? ST_IDLE : ST_DROP;
            end else if (i_axis_master_tlast) begin
              len_err_next = 1'b1;
            end else begin
              addr_next   = hdr_addr[RAM_AW+3:4];
              beats_next  = hdr_beats;
              fbe_next    = i_axis_master_tdata[HDR_FBE_LSB +: 4];
              lbe_next    = i_axis_master_tdata[HDR_LBE_LSB +: 4];
              len_lo_next = hdr_len[1:0];
              first_next  = 1'b1;
              tag_next    = i_axis_master_tdata[HDR_TAG_LSB +: 8];
              rid_next    = i_axis_master_tdata[HDR_RID_LSB +: 16];
              state_next  = ST_DATA;
            end
          end else begin
            drop_next  = 1'b1;
            state_next = i_axis_master_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end

      ST_DATA: begin
        o_axis_master_trdy = i_ram_rdy;
        beat_acc           = i_axis_master_tvld && i_ram_rdy;
        if (beat_acc) begin
          wr_en_next   = 1'b1;
          wr_addr_next = addr_reg;
          wr_data_next = endian_convert(i_axis_master_tdata);
          wr_be_next   = beat_be;
          addr_next    = addr_reg + {{(RAM_AW-1){1'b0}}, 1'b1};
          beats_next   = beats_reg - 9'd1;
          first_next   = 1'b0;
          if (last_beat) begin
            done_next    = i_axis_master_tlast;
            len_err_next = !i_axis_master_tlast;
            state_next   = i_axis_master_tlast ? ST_IDLE : ST_DROP;
          end else if (i_axis_master_tlast) begin
            len_err_next = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        o_axis_master_trdy = 1'b1;
        if (i_axis_master_tvld && i_axis_master_tlast) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      beats_reg     <= '0;
      fbe_reg       <= '0;
      lbe_reg       <= '0;
      len_lo_reg    <= '0;
      first_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_be_reg     <= '0;
      done_reg      <= 1'b0;
      len_err_reg   <= 1'b0;
      align_err_reg <= 1'b0;
      drop_reg      <= 1'b0;
      tag_reg       <= '0;
      rid_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      beats_reg     <= beats_next;
      fbe_reg       <= fbe_next;
      lbe_reg       <= lbe_next;
      len_lo_reg    <= len_lo_next;
      first_reg     <= first_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_be_reg     <= wr_be_next;
      done_reg      <= done_next;
      len_err_reg   <= len_err_next;
      align_err_reg <= align_err_next;
      drop_reg      <= drop_next;
      tag_reg       <= tag_next;
      rid_reg       <= rid_next;
    end
  end

  assign o_wr_en       = wr_en_reg;
  assign o_wr_addr     = wr_addr_reg;
  assign o_wr_data     = wr_data_reg;
  assign o_wr_be       = wr_be_reg;
  assign o_mwr_done    = done_reg;
  assign o_len_err     = len_err_reg;
  assign o_align_err   = align_err_reg;
  assign o_rx_tag      = tag_reg;
  assign o_rx_req_id   = rid_reg;
  assign o_mwr_rx_busy = (state_reg != ST_IDLE);

`ifdef PCIE_MWR_RX_STAT_EN
  logic [15:0] tlp_cnt_reg, drop_cnt_reg;
  logic        drop_evt;

  // an aligned/length error already implies the TLP was dropped, so it counts once
  assign drop_evt = drop_reg | len_err_reg | align_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else if (i_stat_clr) begin
      tlp_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (done_reg && (tlp_cnt_reg != 16'hffff)) tlp_cnt_reg <= tlp_cnt_reg + 16'd1;
      if (drop_evt && (drop_cnt_reg != 16'hffff)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign o_rx_tlp_cnt  = tlp_cnt_reg;
  assign o_rx_drop_cnt = drop_cnt_reg;
`else
  logic unused_drop;
  assign unused_drop = drop_reg;
`endif

endmodule
